// File: rtl/alu_ram_pkg.sv
// -----------------------------------------------------------------------------
// alu_ram_pkg
// Shared definitions for the pipelined ALU + result-memory block:
//   - 4-bit opcode encodings
//   - bit positions of the {N,V,C,Z} flag vector
// -----------------------------------------------------------------------------
package alu_ram_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_NOT   = 4'h4;
  localparam logic [3:0] OP_NAND  = 4'h5;
  localparam logic [3:0] OP_NOR   = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_XNOR  = 4'h8;
  localparam logic [3:0] OP_INC   = 4'h9;
  localparam logic [3:0] OP_DEC   = 4'hA;
  localparam logic [3:0] OP_LEFT  = 4'hB;
  localparam logic [3:0] OP_RIGHT = 4'hC;
  localparam logic [3:0] OP_ARTH  = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_ram_if.sv
// -----------------------------------------------------------------------------
// alu_ram_if
// Bundles the op-input handshake, result handshake, read port and counter of
// alu_ram_pipe.
//   master : sequencer / consumer side (drives ops, out_ready, reads)
//   slave  : alu_ram_pipe side
// Parameters WIDTH (operand width) and DEPTH (memory entries), AW = $clog2(DEPTH).
// -----------------------------------------------------------------------------
interface alu_ram_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic               in_valid;
  logic               in_ready;
  logic [3:0]         opcode;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               b_from_mem;
  logic [AW-1:0]      b_addr;
  logic [AW-1:0]      dst_addr;
  logic               wr_en;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic [3:0]         flags;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [2*WIDTH-1:0] rd_data;
  logic [15:0]        op_count;

  modport master (
    output in_valid, opcode, opa, opb, b_from_mem, b_addr, dst_addr, wr_en,
           out_ready, rd_en, rd_addr,
    input  in_ready, out_valid, result, flags, rd_data, op_count
  );

  modport slave (
    input  in_valid, opcode, opa, opb, b_from_mem, b_addr, dst_addr, wr_en,
           out_ready, rd_en, rd_addr,
    output in_ready, out_valid, result, flags, rd_data, op_count
  );
endinterface

// File: rtl/alu_ram_core.sv
// -----------------------------------------------------------------------------
// alu_ram_core
// Purely combinational ALU: (opcode_i, a_i, b_i) -> (result_o, flags_o).
//   opcode_i  4      operation select
//   a_i, b_i  WIDTH  operands
//   result_o  2*WIDTH packed result
//   flags_o   4      {N,V,C,Z}
// Optional build macro ALU_RAM_SAT_EN: ADD/INC clamp to all-ones, SUB/DEC clamp
// to zero; C still reports the raw carry/borrow.
// -----------------------------------------------------------------------------
module alu_ram_core
  import alu_ram_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]         opcode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic [3:0]         flags_o
);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] x);
    return {ZERO, x};
  endfunction

  // Extra top bit holds the carry (add) or borrow (subtract).
  logic [WIDTH:0] sum_s, diff_s, inc_s, dec_s;
  logic           add_v_s, sub_v_s, inc_v_s, dec_v_s;
  logic [2*WIDTH-1:0] res_s;
  logic           c_s, v_s;

  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s = {1'b0, a_i} - {1'b0, b_i};
  assign inc_s  = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_s  = {1'b0, a_i} - {{WIDTH{1'b0}}, 1'b1};

  // Signed overflow: operand signs vs. sign of the truncated result.
  assign add_v_s = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1]  != a_i[WIDTH-1]);
  assign sub_v_s = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
  assign inc_v_s = !a_i[WIDTH-1] &&  inc_s[WIDTH-1];
  assign dec_v_s =  a_i[WIDTH-1] && !dec_s[WIDTH-1];

  // Operation select: packed result plus carry and overflow.
  always_comb begin
    res_s = {(2*WIDTH){1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        c_s = sum_s[WIDTH];
        v_s = add_v_s;
`ifdef ALU_RAM_SAT_EN
        res_s = zext(sum_s[WIDTH] ? ONES : sum_s[WIDTH-1:0]);
`else
        res_s = {{(WIDTH-1){1'b0}}, sum_s};
`endif
      end
      OP_SUB: begin
        c_s = diff_s[WIDTH];
        v_s = sub_v_s;
`ifdef ALU_RAM_SAT_EN
        res_s = zext(diff_s[WIDTH] ? ZERO : diff_s[WIDTH-1:0]);
`else
        res_s = zext(diff_s[WIDTH-1:0]);
`endif
      end
      OP_INC: begin
        c_s = inc_s[WIDTH];
        v_s = inc_v_s;
`ifdef ALU_RAM_SAT_EN
        res_s = zext(inc_s[WIDTH] ? ONES : inc_s[WIDTH-1:0]);
`else
        res_s = zext(inc_s[WIDTH-1:0]);
`endif
      end
      OP_DEC: begin
        c_s = dec_s[WIDTH];
        v_s = dec_v_s;
`ifdef ALU_RAM_SAT_EN
        res_s = zext(dec_s[WIDTH] ? ZERO : dec_s[WIDTH-1:0]);
`else
        res_s = zext(dec_s[WIDTH-1:0]);
`endif
      end
      OP_AND:   res_s = zext(a_i & b_i);
      OP_OR:    res_s = zext(a_i | b_i);
      OP_NOT:   res_s = {~a_i, ~b_i};
      OP_NAND:  res_s = zext(~(a_i & b_i));
      OP_NOR:   res_s = zext(~(a_i | b_i));
      OP_XOR:   res_s = zext(a_i ^ b_i);
      OP_XNOR:  res_s = zext(~(a_i ^ b_i));
      OP_LEFT: begin
        res_s = {a_i[WIDTH-2:0], 1'b0, b_i[WIDTH-2:0], 1'b0};
        c_s   = a_i[WIDTH-1];
      end
      OP_RIGHT: begin
        res_s = {1'b0, a_i[WIDTH-1:1], 1'b0, b_i[WIDTH-1:1]};
        c_s   = a_i[0];
      end
      OP_ARTH: begin
        res_s = zext({a_i[WIDTH-1], a_i[WIDTH-1:1]});
        c_s   = a_i[0];
      end
      OP_MUL:   res_s = a_i * b_i;
      OP_PASSB: res_s = zext(b_i);
      default:  res_s = {(2*WIDTH){1'b0}};
    endcase
  end

  // Flag vector assembly; N looks at the low-half sign bit.
  always_comb begin
    flags_o         = 4'b0000;
    flags_o[FLAG_Z] = (res_s == {(2*WIDTH){1'b0}});
    flags_o[FLAG_C] = c_s;
    flags_o[FLAG_V] = v_s;
    flags_o[FLAG_N] = res_s[WIDTH-1];
  end

  assign result_o = res_s;

endmodule

// File: rtl/alu_ram_pipe.sv
// -----------------------------------------------------------------------------
// alu_ram_pipe
// 1-deep pipelined ALU with a DEPTH-entry result memory.
//   clk, rst_n : clock (posedge) and synchronous active-low reset
//   bus        : alu_ram_if.slave -- op handshake (in_valid/in_ready), result
//                handshake (out_valid/out_ready, result, flags), read port
//                (rd_en/rd_addr/rd_data) and retired-op counter (op_count)
// An op accepted on one edge presents its result on out_valid; on the retire
// edge it is optionally written to mem[dst_addr]. Operand B can come from memory,
// bypassing the pending, not yet written, result.
// Optional build macro ALU_RAM_SAT_EN (saturating arithmetic, see alu_ram_core).
// -----------------------------------------------------------------------------
module alu_ram_pipe
  import alu_ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  alu_ram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               pend_wr_q, pend_wr_d;
  logic [AW-1:0]      pend_dst_q, pend_dst_d;
  logic [15:0]        op_count_q, op_count_d;
  logic [2*WIDTH-1:0] rd_data_q, rd_data_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];

  logic               accept_s, retire_s, bypass_s;
  logic [WIDTH-1:0]   opb_s;
  logic [2*WIDTH-1:0] core_result_s;
  logic [3:0]         core_flags_s;

  assign bus.in_ready = rst_n && (!out_valid_q || bus.out_ready);
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign retire_s     = out_valid_q && bus.out_ready;

  // The pending result has not reached memory yet, so forward it.
  assign bypass_s = out_valid_q && pend_wr_q && (bus.b_addr == pend_dst_q);

  // Operand B source: port, forwarded pending result, or memory.
  always_comb begin
    if (!bus.b_from_mem) begin
      opb_s = bus.opb;
    end else if (bypass_s) begin
      opb_s = result_q[WIDTH-1:0];
    end else begin
      opb_s = mem_q[bus.b_addr][WIDTH-1:0];
    end
  end

  alu_ram_core #(.WIDTH(WIDTH)) u_core (
    .opcode_i (bus.opcode),
    .a_i      (bus.opa),
    .b_i      (opb_s),
    .result_o (core_result_s),
    .flags_o  (core_flags_s)
  );

  // Next state: pipe register load/drain, counter, read port.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    pend_wr_d   = pend_wr_q;
    pend_dst_d  = pend_dst_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      result_d    = core_result_s;
      flags_d     = core_flags_s;
      pend_wr_d   = bus.wr_en;
      pend_dst_d  = bus.dst_addr;
    end else if (retire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    op_count_d = retire_s ? (op_count_q + 16'd1) : op_count_q;
    rd_data_d  = bus.rd_en ? mem_q[bus.rd_addr] : rd_data_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= {(2*WIDTH){1'b0}};
      flags_q     <= 4'b0000;
      pend_wr_q   <= 1'b0;
      pend_dst_q  <= {AW{1'b0}};
      op_count_q  <= 16'd0;
      rd_data_q   <= {(2*WIDTH){1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      pend_wr_q   <= pend_wr_d;
      pend_dst_q  <= pend_dst_d;
      op_count_q  <= op_count_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Write-back on retire; a reset edge drops the pending write.
  always_ff @(posedge clk) begin
    if (rst_n && retire_s && pend_wr_q) begin
      mem_q[pend_dst_q] <= result_q;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_ram_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_ram_pipe
// Directed bench for alu_ram_pipe (WIDTH=8, DEPTH=16). A behavioural model with
// sequential op semantics is compared against the DUT on every falling edge;
// directed literal checks pin the model's arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_ram_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ram_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  alu_ram_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // ---------------- model state ----------------
  bit          live = 1'b0;
  bit          pv = 1'b0;
  logic [15:0] pres = 16'h0000;
  logic [3:0]  pflg = 4'h0;
  bit          pwr = 1'b0;
  int          pdst = 0;
  logic [15:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  logic [15:0] rdd_m = 16'h0000;
  bit          rdd_known = 1'b0;
  logic [15:0] cnt_m = 16'h0000;
  bit          acc_m = 1'b0;

  function automatic int sx(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Spec-level ALU: plain integer arithmetic on 8-bit operands.
  function automatic void alu_m(input int op, input int a, input int b,
                                output logic [15:0] r, output logic [3:0] f);
    int s, sv, bb;
    bit c, v;
    c = 1'b0; v = 1'b0; r = 16'h0000;
    bb = (op == 9 || op == 10) ? 1 : b;
    case (op)
      0, 9: begin
        s = a + bb; sv = sx(a) + sx(bb);
        c = (s > 255); v = (sv > 127) || (sv < -128);
`ifdef ALU_RAM_SAT_EN
        r = c ? 16'h00FF : 16'(s);
`else
        r = (op == 0) ? 16'(s) : 16'(s & 255);
`endif
      end
      1, 10: begin
        s = a - bb; sv = sx(a) - sx(bb);
        c = (s < 0); v = (sv > 127) || (sv < -128);
`ifdef ALU_RAM_SAT_EN
        r = c ? 16'h0000 : 16'(s);
`else
        r = 16'(s & 255);
`endif
      end
      2:  r = 16'(a & b);
      3:  r = 16'(a | b);
      4:  r = 16'((((~a) & 255) << 8) | ((~b) & 255));
      5:  r = 16'((~(a & b)) & 255);
      6:  r = 16'((~(a | b)) & 255);
      7:  r = 16'(a ^ b);
      8:  r = 16'((~(a ^ b)) & 255);
      11: begin r = 16'((((a << 1) & 255) << 8) | ((b << 1) & 255)); c = ((a >> 7) & 1) == 1; end
      12: begin r = 16'(((a >> 1) << 8) | (b >> 1)); c = (a & 1) == 1; end
      13: begin r = 16'((a >> 1) | (a & 128)); c = (a & 1) == 1; end
      14: r = 16'(a * b);
      default: r = 16'(b);
    endcase
    f = {r[7], v, c, (r == 16'h0000)};
  endfunction

  // Memory as seen by the next op: every earlier op's write already applied.
  function automatic logic [15:0] eff(input int addr);
    if (pv && pwr && pdst == addr) return pres;
    return mem_m[addr];
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT sees at this edge.
  task automatic tick();
    bit ready, retire;
    int bv;
    logic [15:0] nr;
    logic [3:0] nf;
    @(posedge clk);
    if (!rst_n) begin
      pv = 1'b0; pres = 16'h0000; pflg = 4'h0; pwr = 1'b0;
      cnt_m = 16'h0000; rdd_m = 16'h0000; rdd_known = 1'b1; acc_m = 1'b0;
    end else begin
      ready  = !pv || bus.out_ready;
      retire = pv && bus.out_ready;
      acc_m  = bus.in_valid && ready;
      nr = 16'h0000; nf = 4'h0;
      if (bus.rd_en) begin
        rdd_m = mem_m[int'(bus.rd_addr)];
        rdd_known = known_m[int'(bus.rd_addr)];
      end
      if (acc_m) begin
        bv = bus.b_from_mem ? int'(eff(int'(bus.b_addr)) & 16'h00FF) : int'(bus.opb);
        alu_m(int'(bus.opcode), int'(bus.opa), bv, nr, nf);
      end
      if (retire) begin
        cnt_m = cnt_m + 16'd1;
        if (pwr) begin mem_m[pdst] = pres; known_m[pdst] = 1'b1; end
      end
      if (acc_m) begin
        pv = 1'b1; pres = nr; pflg = nf; pwr = bus.wr_en; pdst = int'(bus.dst_addr);
      end else if (retire) begin
        pv = 1'b0;
      end
    end
    live = 1'b1;
    #1;
  endtask

  // Compare process: DUT vs. model on every falling edge.
  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", {15'd0, bus.out_valid}, {15'd0, pv});
      chk("in_ready", {15'd0, bus.in_ready}, {15'd0, (rst_n && (!pv || bus.out_ready))});
      if (pv) begin
        chk("result", bus.result, pres);
        chk("flags", {12'd0, bus.flags}, {12'd0, pflg});
      end
      chk("op_count", bus.op_count, cnt_m);
      if (rdd_known) chk("rd_data", bus.rd_data, rdd_m);
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic bfm, input logic [3:0] baddr, input logic [3:0] dst,
                      input logic we);
    bus.opcode = op; bus.opa = a; bus.opb = b; bus.b_from_mem = bfm;
    bus.b_addr = baddr; bus.dst_addr = dst; bus.wr_en = we; bus.in_valid = 1'b1;
    acc_m = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_m) break;
    end
    if (!acc_m) chk("send_timeout", 16'h0000, 16'h0001);
    bus.in_valid = 1'b0;
  endtask

  // Directed vectors: opcode, a, b, expected result, expected flags {N,V,C,Z}.
  localparam int NV = 17;
  logic [3:0]  v_op [NV] = '{4'hE, 4'hD, 4'h1, 4'h0, 4'h1, 4'h9, 4'hA, 4'h2, 4'h3,
                              4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB, 4'hC, 4'hF};
  logic [7:0]  v_a  [NV] = '{8'hFF, 8'h81, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'hF0, 8'hF0,
                              8'h0F, 8'hFF, 8'h00, 8'hAA, 8'hAA, 8'h81, 8'h81, 8'h00};
  logic [7:0]  v_b  [NV] = '{8'hFF, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h3C, 8'h0F,
                              8'hF0, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC3, 8'hC3, 8'h5A};
`ifdef ALU_RAM_SAT_EN
  logic [15:0] v_r  [NV] = '{16'hFE01, 16'h00C0, 16'h0000, 16'h0080, 16'h007F, 16'h00FF,
                              16'h0000, 16'h0030, 16'h00FF, 16'hF00F, 16'h0000, 16'h00FF,
                              16'h00FF, 16'h00FF, 16'h0286, 16'h4061, 16'h005A};
  logic [3:0]  v_f  [NV] = '{4'b0000, 4'b1010, 4'b0011, 4'b1100, 4'b0100, 4'b1010, 4'b0011,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b1000, 4'b1000, 4'b1000,
                              4'b1010, 4'b0010, 4'b0000};
`else
  logic [15:0] v_r  [NV] = '{16'hFE01, 16'h00C0, 16'h00FF, 16'h0080, 16'h007F, 16'h0000,
                              16'h00FF, 16'h0030, 16'h00FF, 16'hF00F, 16'h0000, 16'h00FF,
                              16'h00FF, 16'h00FF, 16'h0286, 16'h4061, 16'h005A};
  logic [3:0]  v_f  [NV] = '{4'b0000, 4'b1010, 4'b1010, 4'b1100, 4'b0100, 4'b0011, 4'b1010,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b1000, 4'b1000, 4'b1000,
                              4'b1010, 4'b0010, 4'b0000};
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem_m[i] = 16'h0000; known_m[i] = 1'b0; end
    bus.in_valid = 1'b1; bus.opcode = 4'h0; bus.opa = 8'h00; bus.opb = 8'h00;
    bus.b_from_mem = 1'b0; bus.b_addr = 4'h0; bus.dst_addr = 4'h0; bus.wr_en = 1'b0;
    bus.out_ready = 1'b1; bus.rd_en = 1'b0; bus.rd_addr = 4'h0;

    // 1. reset with in_valid high
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'h0000);
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'h0000);
    chk("rst_op_count", bus.op_count, 16'h0000);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_rd_data", bus.rd_data, 16'h0000);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {15'd0, bus.in_ready}, 16'h0001);

    // 2. ADD FF+01
    send(4'h0, 8'hFF, 8'h01, 1'b0, 4'h0, 4'h0, 1'b0);
`ifdef ALU_RAM_SAT_EN
    chk("add_ff01_res", bus.result, 16'h00FF);
    chk("add_ff01_flg", {12'd0, bus.flags}, 16'h000A);
`else
    chk("add_ff01_res", bus.result, 16'h0100);
    chk("add_ff01_flg", {12'd0, bus.flags}, 16'h0002);
`endif
    tick();

    // 3. back-pressure: first op held, second not taken
    bus.out_ready = 1'b0;
    send(4'h0, 8'h10, 8'h20, 1'b0, 4'h0, 4'h0, 1'b0);
    bus.opcode = 4'h7; bus.opa = 8'h0F; bus.opb = 8'hF0; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", {15'd0, bus.in_ready}, 16'h0000);
      chk("bp_hold", bus.result, 16'h0030);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("bp_second", bus.result, 16'h00FF);
    tick();
    chk("bp_drained", {15'd0, bus.out_valid}, 16'h0000);
    chk("bp_count", bus.op_count, 16'h0003);

    // 4. write-back, bypass on same-edge retire, held output, read-back
    send(4'h0, 8'h03, 8'h04, 1'b0, 4'h0, 4'h5, 1'b1);
    send(4'h0, 8'h01, 8'h00, 1'b1, 4'h5, 4'h0, 1'b0);
    chk("bypass_res", bus.result, 16'h0008);
    bus.out_ready = 1'b0;
    tick(); tick();
    chk("bypass_hold", bus.result, 16'h0008);
    bus.out_ready = 1'b1;
    tick();
    bus.rd_en = 1'b1; bus.rd_addr = 4'h5;
    tick();
    bus.rd_en = 1'b0;
    chk("rd_addr5", bus.rd_data, 16'h0007);
    send(4'hF, 8'h00, 8'h00, 1'b1, 4'h5, 4'h0, 1'b0);
    chk("mem_b", bus.result, 16'h0007);

    // 5. opcode table (each send also retires the previous op)
    for (int i = 0; i < NV; i++) begin
      send(v_op[i], v_a[i], v_b[i], 1'b0, 4'h0, 4'h0, 1'b0);
      chk("vec_res", bus.result, v_r[i]);
      chk("vec_flg", {12'd0, bus.flags}, {12'd0, v_f[i]});
    end
    tick();

    // reset mid-op drops the pending write
    send(4'h0, 8'h01, 8'h01, 1'b0, 4'h0, 4'h9, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    send(4'h0, 8'h04, 8'h04, 1'b0, 4'h0, 4'h9, 1'b1);
    bus.out_ready = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.rd_en = 1'b1; bus.rd_addr = 4'h9;
    tick();
    bus.rd_en = 1'b0;
    chk("rst_drop_wr", bus.rd_data, 16'h0002);

    // 6a. same-edge read and write of addr 3 returns old data
    send(4'h0, 8'h01, 8'h01, 1'b0, 4'h0, 4'h3, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    send(4'h0, 8'h05, 8'h05, 1'b0, 4'h0, 4'h3, 1'b1);
    bus.out_ready = 1'b1; bus.rd_en = 1'b1; bus.rd_addr = 4'h3;
    tick();
    chk("rdwr_old", bus.rd_data, 16'h0002);
    tick();
    bus.rd_en = 1'b0;
    chk("rdwr_new", bus.rd_data, 16'h000A);

    // 6b. 65536 retires wrap op_count
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.opcode = 4'h0; bus.opa = 8'h01; bus.opb = 8'h02; bus.b_from_mem = 1'b0;
    bus.wr_en = 1'b0; bus.in_valid = 1'b1;
    repeat (65535) tick();
    chk("cnt_fffe", bus.op_count, 16'hFFFE);
    tick();
    chk("cnt_ffff", bus.op_count, 16'hFFFF);
    bus.in_valid = 1'b0;
    tick();
    chk("cnt_wrap", bus.op_count, 16'h0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
